// File: rtl/upcpu_acc_master.sv
// Host-side initiator for the shared-memory access port.
// Turns one host request into a strobe, waits for uprdy, times out on silence.
module upcpu_acc_master #(
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32,
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hst_req,
  input  logic               hst_wr,
  input  logic [ADDRBIT-1:0] hst_addr,
  input  logic [WIDTH-1:0]   hst_wdata,
  output logic               hst_busy,
  output logic               hst_ack,
  output logic               hst_err,
  output logic [WIDTH-1:0]   hst_rdata,
  output logic               upen,
  output logic               upws,
  output logic               uprs,
  output logic [ADDRBIT-1:0] upa,
  output logic [WIDTH-1:0]   updi,
  input  logic [WIDTH-1:0]   updo,
  input  logic               uprdy,
  output logic [15:0]        tmo_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    DONE
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state;
  logic             wr_q;
  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      cnt       <= '0;
      hst_busy  <= 1'b0;
      hst_ack   <= 1'b0;
      hst_err   <= 1'b0;
      hst_rdata <= '0;
      upen      <= 1'b0;
      upws      <= 1'b0;
      uprs      <= 1'b0;
      upa       <= '0;
      updi      <= '0;
      tmo_cnt   <= '0;
    end else begin
      hst_ack <= 1'b0;
      upws    <= 1'b0;
      uprs    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hst_req) begin
            state    <= STROBE;
            wr_q     <= hst_wr;
            upa      <= hst_addr;
            if (hst_wr) updi <= hst_wdata;
            upen     <= 1'b1;
            upws     <= hst_wr;
            uprs     <= ~hst_wr;
            hst_busy <= 1'b1;
          end
        end
        STROBE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a response in the expiry cycle still counts as success
          if (uprdy) begin
            hst_rdata <= wr_q ? '0 : updo;
            hst_err   <= 1'b0;
            hst_ack   <= 1'b1;
            upen      <= 1'b0;
            state     <= DONE;
          end else if (cnt == TMO_LAST) begin
            hst_rdata <= '0;
            hst_err   <= 1'b1;
            hst_ack   <= 1'b1;
            upen      <= 1'b0;
            if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          hst_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/upcpu_acc_master.md
Name: upcpu_acc_master

Overview:
- CPU-side initiator for the engine/CPU shared-memory access port (upen/upa/upws/uprs/updi/updo/uprdy).
- Converts single host-bus read/write requests into the strobe-and-hold sequence the memory-access responder expects.
- Waits for uprdy, returns the read data, and aborts with an error flag on timeout.
- Sits between the host register decoder and each memory-access responder instance.

Parameters:
- ADDRBIT, 5, address width of upa/hst_addr.
- WIDTH, 32, data width.
- TMO_CYC, 255, WAIT-state cycles allowed before abort; range 1..2^TMO_W-1.
- TMO_W, 8, timeout counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- hst_req  in  1  host request; sampled only in IDLE.
- hst_wr  in  1  1 = write, 0 = read; qualified by hst_req.
- hst_addr  in  ADDRBIT  host address; qualified by hst_req.
- hst_wdata  in  WIDTH  host write data; qualified by hst_req.
- hst_busy  out  1  high whenever state != IDLE.
- hst_ack  out  1  one-cycle completion pulse.
- hst_err  out  1  valid with hst_ack; 1 = timeout abort.
- hst_rdata  out  WIDTH  read data, valid with hst_ack.
- upen  out  1  access enable; held high for the whole transaction.
- upws  out  1  write strobe; one cycle.
- uprs  out  1  read strobe; one cycle.
- upa  out  ADDRBIT  access address.
- updi  out  WIDTH  write data.
- updo  in  WIDTH  responder read data; sampled only when uprdy=1.
- uprdy  in  1  responder completion pulse.
- tmo_cnt  out  16  count of timeouts; saturates at 16'hFFFF.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; upen=upws=uprs=0; upa=0; updi=0; hst_ack=hst_err=0; hst_rdata=0; hst_busy=0; tmo_cnt=0.
- Reset mid-transaction: next cycle IDLE with upen=0. No ack is issued for the aborted access.
- States: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - On hst_req=1: latch hst_addr into upa and hst_wdata into updi (writes only; updi unchanged on reads) and remember hst_wr.
  - Go to STROBE.
- STROBE (1 cycle):
  - upen=1; upws=hst_wr_latched, uprs=~hst_wr_latched.
  - Timeout counter cleared to 0. Go to WAIT.
- WAIT:
  - upen=1, upws=uprs=0; upa/updi held stable.
  - uprdy=1: capture hst_rdata<=updo on reads (0 on writes), err=0, go to DONE.
  - Else, counter==TMO_CYC-1: err=1, hst_rdata<=0, tmo_cnt+=1 (saturating), go to DONE.
  - Else counter+=1.
  - uprdy and expiry in the same cycle: uprdy wins, err=0, tmo_cnt unchanged.
- DONE (1 cycle):
  - upen=0 (clears any pending responder latch after an abort).
  - hst_ack=1, hst_err per outcome, hst_busy still 1. Go to IDLE.
- Minimum upen-low gap between transactions: 2 cycles (DONE plus IDLE).
- hst_req in any state other than IDLE is ignored. The host must hold it until it sees hst_busy=1 or resubmit it.
- uprdy outside WAIT (late response after abort, or a spurious pulse) is ignored; updo is not captured.
- Latency, with uprdy arriving N cycles after the STROBE cycle (N>=1): hst_req sampled at cycle 0, STROBE at cycle 1, uprdy at cycle 1+N, hst_ack at cycle 2+N.
- hst_rdata holds its value until the next ack.

Test Plan:
- Read: hst_addr=5'h0A, responder model returns uprdy 4 cycles after the strobe with updo=32'hDEADBEEF → uprs pulses 1 cycle at cycle 1, upen high cycles 1..5, hst_ack at cycle 6 with hst_rdata=32'hDEADBEEF, hst_err=0.
- Write: hst_addr=5'h1F, hst_wdata=32'h12345678 → upws pulse at cycle 1 with upa=5'h1F and updi=32'h12345678 stable until DONE; ack with err=0 and hst_rdata=0.
- Timeout: TMO_CYC=8, no uprdy → upen drops after 1 STROBE + 8 WAIT cycles; hst_ack with hst_err=1; tmo_cnt=1. A uprdy pulse 2 cycles later is ignored and produces no second ack.
- Boundary: uprdy exactly in the WAIT cycle where the counter reaches TMO_CYC-1 → err=0, data captured, tmo_cnt unchanged.
- Back-to-back: hst_req held high continuously → a new strobe every transaction with exactly a 2-cycle upen-low gap; the second hst_addr is latched only in IDLE.
- Reset asserted in WAIT → next cycle upen=0, hst_busy=0, no hst_ack. tmo_cnt preloaded to 16'hFFFF stays saturated after a further timeout.
